conv_psum_accum: RTL and testbench
==================================

CONV_PSUM_ACCUM -- requirements
Module: conv_psum_accum

Interface
REQ-001 Parameter W, default 64: signed multiplier product width.
REQ-002 Parameter F, default 3: filter height and width.
REQ-003 Parameter K, default 3: input channels.
REQ-004 Parameter NF, default 3: number of filters.
REQ-005 Parameter OUT_SZ, default 32: output feature-map height and width, equal to (N-F+2P)/S+1 with N=32, P=1, S=1.
REQ-006 Derived TAPS = F*F*K (27) and ACC_W = W+5; ACC_W SHALL be at least W+ceil(log2(TAPS)).
REQ-007 clk  in  1  clock, all state updates on the rising edge.
REQ-008 rstn  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  single-cycle frame start request.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 done  out  1  one-cycle pulse when the frame is complete.
REQ-012 prod_valid  in  1  product available from the multiplier pool.
REQ-013 prod_ready  out  1  accumulator accepts the product this cycle.
REQ-014 prod_data  in  W  signed product.
REQ-015 acc_valid  out  1  output pixel valid.
REQ-016 acc_ready  in  1  downstream accepts the output pixel.
REQ-017 acc_data  out  ACC_W  signed sum of TAPS products.
REQ-018 acc_row / acc_col  out  clog2(OUT_SZ) each  output pixel coordinates.
REQ-019 acc_filt  out  clog2(NF)  filter index of the output pixel.

Function
REQ-020 The FSM SHALL have states IDLE, ACCUM, FLUSH and DONE.
REQ-021 IDLE→ACCUM on start; this transition SHALL clear the accumulator, tap counter, row, col and filter counters.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 A product handshake occurs when prod_valid && prod_ready.
REQ-024 prod_ready SHALL equal (state==ACCUM) && (!acc_valid || acc_ready).
REQ-025 On each handshake: sum += sign-extended prod_data; tap_cnt += 1.
REQ-026 On the handshake with tap_cnt==TAPS-1:
- acc_data SHALL load sum+prod_data.
- acc_valid SHALL be set.
- The coordinate outputs SHALL load the current counters.
- sum and tap_cnt SHALL clear.
- Latency: the result is visible in the cycle after the last product.
REQ-027 Pixel order: col fastest, then row, then filt; each counter wraps to 0 at its maximum, and carries into the next counter.
REQ-028 acc_valid, acc_data and the coordinate outputs SHALL hold stable until acc_ready is sampled high.
REQ-029 A simultaneous output accept and new final-tap handshake SHALL reload the output register with no bubble.
REQ-030 After the final-tap handshake for pixel (OUT_SZ-1, OUT_SZ-1, NF-1), ACCUM→FLUSH.
REQ-031 FLUSH→DONE once the output is accepted; DONE SHALL assert done for one cycle, then DONE→IDLE.
REQ-032 A frame SHALL emit exactly OUT_SZ*OUT_SZ*NF (3072) results.
REQ-033 Arithmetic SHALL be two's-complement; overflow is impossible by the width rule in REQ-006.

Reset
REQ-034 rstn low SHALL force, asynchronously and at any time including mid-frame:
- state to IDLE;
- sum, counters and acc_data to 0;
- acc_valid, done, busy and prod_ready to 0.
REQ-035 After reset deassertion, no output SHALL change until start is received.

Structure
REQ-036 Shared package conv_pkg SHALL hold the following, reused by the controller and the multiplier pool:
- N, F, K, NF, P, S, W, OUT_SZ, TAPS, ACC_W;
- the state enum.
REQ-037 A single sub-module conv_out_slice (a one-entry valid/ready holding register) is natural; the FSM, counters and adder remain in the top.

Verification
REQ-038 Back-to-back frame, all prod_data=1, acc_ready=1 → 3072 results, each acc_data=27, coordinates in col/row/filt order, then one done pulse.
REQ-039 Products -5, 3, then 25 × 0 → acc_data = -2, sign-extended to ACC_W.
REQ-040 27 × (2^(W-1)-1) → acc_data = 27*(2^63-1) exactly, no wrap.
REQ-041 acc_ready low for 10 cycles after the first result → prod_ready low during the stall; acc_data held; no product lost or duplicated.
REQ-042 rstn pulsed after 100 products, then start reissued → all outputs 0 during reset; first result after restart = the sum of the fresh 27 products.
REQ-043 start pulsed while busy → ignored; result count unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution datapath
// (partial-sum accumulator and multiplier pool).
package conv_pkg;

    localparam int N      = 32;
    localparam int F      = 3;
    localparam int K      = 3;
    localparam int NF     = 3;
    localparam int P      = 1;
    localparam int S      = 1;
    localparam int W      = 64;
    localparam int OUT_SZ = (N - F + 2 * P) / S + 1;
    localparam int TAPS   = F * F * K;
    localparam int ACC_W  = W + 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_t;

    // Index width for a counter over 'depth' values, never narrower than 1 bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_out_slice.sv
// One-entry valid/ready holding register for the finished output pixel.
// A load always wins; the owner only loads when the slot is empty or draining.
module conv_out_slice #(
    parameter int DW = conv_pkg::ACC_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_psum_accum.sv
// Accumulates TAPS signed products per output pixel and emits one sum per
// pixel in col/row/filter order over a full frame.
module conv_psum_accum #(
    parameter int  W      = conv_pkg::W,
    parameter int  F      = conv_pkg::F,
    parameter int  K      = conv_pkg::K,
    parameter int  NF     = conv_pkg::NF,
    parameter int  OUT_SZ = conv_pkg::OUT_SZ,
    localparam int TAPS   = F * F * K,
    localparam int ACC_W  = W + 5,
    localparam int CW     = conv_pkg::idx_w(OUT_SZ),
    localparam int FW     = conv_pkg::idx_w(NF)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    input  logic signed [W-1:0]     prod_data,
    output logic                    acc_valid,
    input  logic                    acc_ready,
    output logic signed [ACC_W-1:0] acc_data,
    output logic [CW-1:0]           acc_row,
    output logic [CW-1:0]           acc_col,
    output logic [FW-1:0]           acc_filt
);

    import conv_pkg::*;

    localparam int              TW        = idx_w(TAPS);
    localparam int              SW        = FW + 2 * CW + ACC_W;
    localparam logic [TW-1:0]   LAST_TAP  = TW'(TAPS - 1);
    localparam logic [CW-1:0]   LAST_POS  = CW'(OUT_SZ - 1);
    localparam logic [FW-1:0]   LAST_FILT = FW'(NF - 1);

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_final;
    logic [TW-1:0]           tap_cnt;
    logic [CW-1:0]           row, col;
    logic [FW-1:0]           filt;
    logic                    prod_hs, last_tap, last_pixel, frame_start;
    logic [SW-1:0]           slice_d, slice_q;

    assign prod_ext    = {{(ACC_W - W){prod_data[W-1]}}, prod_data};
    assign sum_final   = sum + prod_ext;
    assign prod_ready  = (state == ACCUM) && (!acc_valid || acc_ready);
    assign prod_hs     = prod_valid && prod_ready;
    assign last_tap    = (tap_cnt == LAST_TAP);
    assign last_pixel  = (col == LAST_POS) && (row == LAST_POS) && (filt == LAST_FILT);
    assign frame_start = (state == IDLE) && start;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (prod_hs && last_tap && last_pixel) state_next = FLUSH;
            FLUSH:   if (acc_valid && acc_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final tap bypasses sum: it goes straight to the output slot while
    // the accumulator restarts for the next pixel in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum     <= '0;
            tap_cnt <= '0;
            row     <= '0;
            col     <= '0;
            filt    <= '0;
        end else if (frame_start) begin
            sum     <= '0;
            tap_cnt <= '0;
            row     <= '0;
            col     <= '0;
            filt    <= '0;
        end else if (prod_hs) begin
            if (last_tap) begin
                sum     <= '0;
                tap_cnt <= '0;
                if (col == LAST_POS) begin
                    col <= '0;
                    if (row == LAST_POS) begin
                        row  <= '0;
                        filt <= (filt == LAST_FILT) ? '0 : filt + FW'(1);
                    end else begin
                        row <= row + CW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end else begin
                sum     <= sum_final;
                tap_cnt <= tap_cnt + TW'(1);
            end
        end
    end

    assign slice_d = {filt, row, col, sum_final};

    conv_out_slice #(
        .DW (SW)
    ) u_out_slice (
        .clk   (clk),
        .rstn  (rstn),
        .load  (prod_hs && last_tap),
        .d     (slice_d),
        .valid (acc_valid),
        .ready (acc_ready),
        .q     (slice_q)
    );

    assign acc_data = slice_q[ACC_W-1:0];
    assign acc_col  = slice_q[ACC_W +: CW];
    assign acc_row  = slice_q[ACC_W + CW +: CW];
    assign acc_filt = slice_q[ACC_W + 2 * CW +: FW];

endmodule

// File: tb/tb_conv_psum_accum.sv
// Self-checking bench for conv_psum_accum: first-pixel vector table, full
// frames against a queue-based reference model, stall, restart and reset cases.
module tb_conv_psum_accum;

    import conv_pkg::*;

    localparam int T_OUT = 5;
    localparam int FRAME = T_OUT * T_OUT * NF;
    localparam int CW    = idx_w(T_OUT);
    localparam int FW    = idx_w(NF);
    localparam logic signed [W-1:0] PMAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic signed [W-1:0] PMIN = {1'b1, {(W - 1){1'b0}}};

    typedef struct {
        logic signed [127:0] data;
        int                  row;
        int                  col;
        int                  filt;
    } result_t;

    typedef struct {
        logic signed [W-1:0] p0;
        logic signed [W-1:0] p1;
        logic signed [W-1:0] rest;
        logic signed [127:0] expected;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    prod_valid;
    logic                    prod_ready;
    logic signed [W-1:0]     prod_data;
    logic                    acc_valid;
    logic                    acc_ready;
    logic signed [ACC_W-1:0] acc_data;
    logic [CW-1:0]           acc_row;
    logic [CW-1:0]           acc_col;
    logic [FW-1:0]           acc_filt;

    int                  checks = 0;
    int                  errors = 0;
    result_t             exp_q[$];
    logic signed [127:0] model_sum;
    int                  model_taps;
    int                  model_pix;
    int                  result_cnt = 0;
    int                  done_cnt = 0;
    int                  prod_cnt = 0;
    bit                  last_prod_hs;

    conv_psum_accum #(
        .W      (W),
        .F      (F),
        .K      (K),
        .NF     (NF),
        .OUT_SZ (T_OUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_data   (acc_data),
        .acc_row    (acc_row),
        .acc_col    (acc_col),
        .acc_filt   (acc_filt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic signed [127:0] actual,
                               input logic signed [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        exp_q.delete();
        model_sum  = 0;
        model_taps = 0;
        model_pix  = 0;
    endtask

    // Called at a negedge with inputs already driven; samples mid-cycle, then
    // advances to the next negedge.
    task automatic stepCycle();
        result_t r;
        result_t e;
        #1;
        last_prod_hs = 1'b0;
        if (done) done_cnt++;
        if (acc_valid && !acc_ready) checkOutput("prod_ready low while output stalled", prod_ready, 0);
        if (acc_valid && acc_ready) begin
            result_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected extra result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("acc_data", acc_data, e.data);
                checkOutput("acc_row", acc_row, e.row);
                checkOutput("acc_col", acc_col, e.col);
                checkOutput("acc_filt", acc_filt, e.filt);
            end
        end
        if (prod_valid && prod_ready) begin
            last_prod_hs = 1'b1;
            prod_cnt++;
            model_sum = model_sum + prod_data;
            model_taps++;
            if (model_taps == TAPS) begin
                r.data = model_sum;
                r.col  = model_pix % T_OUT;
                r.row  = (model_pix / T_OUT) % T_OUT;
                r.filt = model_pix / (T_OUT * T_OUT);
                exp_q.push_back(r);
                model_pix  = (model_pix + 1) % FRAME;
                model_sum  = 0;
                model_taps = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit st, input bit pv, input logic signed [W-1:0] pd,
                                 input bit ar);
        start      = st;
        prod_valid = pv;
        prod_data  = pd;
        acc_ready  = ar;
        stepCycle();
    endtask

    function automatic logic signed [W-1:0] randProd();
        logic signed [W-1:0] x;
        case ($urandom_range(0, 7))
            0:       x = PMAX;
            1:       x = PMIN;
            2: begin
                x = $urandom_range(0, 200);
                x = x - 100;
            end
            default: x = {$urandom, $urandom};
        endcase
        return x;
    endfunction

    // Reset is dropped between clock edges so the checks show it acting asynchronously.
    task automatic doReset();
        #2 rstn = 1'b0;
        start = 1'b0;
        clearModel();
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset prod_ready", prod_ready, 0);
        checkOutput("reset acc_valid", acc_valid, 0);
        checkOutput("reset acc_data", acc_data, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic quietCheck();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, randProd(), 1'b1);
            checkOutput("idle busy", busy, 0);
            checkOutput("idle prod_ready", prod_ready, 0);
            checkOutput("idle acc_valid", acc_valid, 0);
            checkOutput("idle acc_data", acc_data, 0);
        end
    endtask

    task automatic feedProduct(input logic signed [W-1:0] val);
        int n = 0;
        do begin
            applyStimulus(1'b0, 1'b1, val, 1'b0);
            n++;
        end while (!last_prod_hs && n < 20);
        if (!last_prod_hs) checkOutput("product accept timeout", 0, 1);
    endtask

    task automatic runFrame(input bit ones, input bit rand_valid, input bit rand_ready,
                            input bit start_noise, input bit stall_first);
        int                  res0 = result_cnt;
        int                  stall_cnt = 0;
        logic signed [127:0] held = 0;
        bit                  st, pv, ar;
        logic signed [W-1:0] pd;
        done_cnt = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int cyc = 0; cyc < 20000 && done_cnt == 0; cyc++) begin
            st = start_noise && ($urandom_range(0, 15) == 0);
            pv = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            pd = ones ? W'(1) : randProd();
            ar = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_first && stall_cnt < 10) begin
                ar = 1'b0;
                if (acc_valid) begin
                    if (stall_cnt == 0) held = acc_data;
                    else checkOutput("stall acc_data held", acc_data, held);
                    stall_cnt++;
                end
            end
            applyStimulus(st, pv, pd, ar);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("frame result count", result_cnt - res0, FRAME);
        checkOutput("done pulse count", done_cnt, 1);
        checkOutput("scoreboard drained", exp_q.size(), 0);
        checkOutput("busy after frame", busy, 0);
    endtask

    initial begin
        vec_t vecs[6];
        logic signed [W-1:0] v;

        vecs[0] = '{p0: -64'sd5, p1: 64'sd3, rest: 64'sd0, expected: -128'sd2};
        vecs[1] = '{p0: 64'sd1, p1: 64'sd1, rest: 64'sd1, expected: 128'sd27};
        vecs[2] = '{p0: PMAX, p1: PMAX, rest: PMAX, expected: 128'sd249031044995078946789};
        vecs[3] = '{p0: PMIN, p1: PMIN, rest: PMIN, expected: -128'sd249031044995078946816};
        vecs[4] = '{p0: -64'sd1, p1: -64'sd1, rest: -64'sd1, expected: -128'sd27};
        vecs[5] = '{p0: 64'sd100, p1: -64'sd100, rest: 64'sd7, expected: 128'sd175};

        rstn       = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        acc_ready  = 1'b0;
        clearModel();
        @(negedge clk);
        doReset();
        quietCheck();

        $display("[TB] first-pixel vector table");
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            for (int t = 0; t < TAPS; t++) begin
                v = (t == 0) ? vecs[i].p0 : (t == 1) ? vecs[i].p1 : vecs[i].rest;
                feedProduct(v);
            end
            prod_valid = 1'b0;
            #1;
            checkOutput("vec acc_valid next cycle", acc_valid, 1);
            checkOutput("vec acc_data", acc_data, vecs[i].expected);
            checkOutput("vec acc_row", acc_row, 0);
            checkOutput("vec acc_col", acc_col, 0);
            checkOutput("vec acc_filt", acc_filt, 0);
        end

        $display("[TB] back-to-back frames");
        doReset();
        runFrame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("[TB] output stall after first result");
        runFrame(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("[TB] reset mid-frame then restart");
        prod_cnt = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int g = 0; g < 1000 && prod_cnt < 100; g++) applyStimulus(1'b0, 1'b1, randProd(), 1'b1);
        checkOutput("products before reset", prod_cnt, 100);
        doReset();
        quietCheck();
        runFrame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
